// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and scan-code to ASCII lookup for the
// PS/2 key decoder.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;  // extended-key prefix
    localparam logic [7:0] PS2_BRK   = 8'hF0;  // break (key release) prefix
    localparam logic [7:0] SEG_BLANK = 8'hFF;  // all segments off, dp off

    // Prefix-tracking states of the set-2 byte stream
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } ps2_state_t;

    // Set-2 make code to ASCII; letters map to lowercase, unmapped codes to 0
    function automatic logic [7:0] scan2ascii(input logic [7:0] code);
        logic [7:0] ascii;
        ascii = 8'h00;
        case (code)
            8'h1C: ascii = 8'h61;  // a
            8'h32: ascii = 8'h62;  // b
            8'h21: ascii = 8'h63;  // c
            8'h23: ascii = 8'h64;  // d
            8'h24: ascii = 8'h65;  // e
            8'h2B: ascii = 8'h66;  // f
            8'h34: ascii = 8'h67;  // g
            8'h33: ascii = 8'h68;  // h
            8'h43: ascii = 8'h69;  // i
            8'h3B: ascii = 8'h6A;  // j
            8'h42: ascii = 8'h6B;  // k
            8'h4B: ascii = 8'h6C;  // l
            8'h3A: ascii = 8'h6D;  // m
            8'h31: ascii = 8'h6E;  // n
            8'h44: ascii = 8'h6F;  // o
            8'h4D: ascii = 8'h70;  // p
            8'h15: ascii = 8'h71;  // q
            8'h2D: ascii = 8'h72;  // r
            8'h1B: ascii = 8'h73;  // s
            8'h2C: ascii = 8'h74;  // t
            8'h3C: ascii = 8'h75;  // u
            8'h2A: ascii = 8'h76;  // v
            8'h1D: ascii = 8'h77;  // w
            8'h22: ascii = 8'h78;  // x
            8'h35: ascii = 8'h79;  // y
            8'h1A: ascii = 8'h7A;  // z
            8'h45: ascii = 8'h30;  // 0
            8'h16: ascii = 8'h31;  // 1
            8'h1E: ascii = 8'h32;  // 2
            8'h26: ascii = 8'h33;  // 3
            8'h25: ascii = 8'h34;  // 4
            8'h2E: ascii = 8'h35;  // 5
            8'h36: ascii = 8'h36;  // 6
            8'h3D: ascii = 8'h37;  // 7
            8'h3E: ascii = 8'h38;  // 8
            8'h46: ascii = 8'h39;  // 9
            8'h29: ascii = 8'h20;  // space
            8'h5A: ascii = 8'h0D;  // enter
            default: ascii = 8'h00;
        endcase
        return ascii;
    endfunction

endpackage

// File: rtl/seg7_hex.sv
// One hexadecimal digit on an active-low 7-segment display, {dp,g..a}.
// The decimal point is never lit; 'blank' turns the whole digit off.
module seg7_hex
    import ps2_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [7:0] seg
);

    // Glyph decode; bit 7 (dp) stays high in every pattern
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (nibble)
                4'h0: seg = 8'hC0;
                4'h1: seg = 8'hF9;
                4'h2: seg = 8'hA4;
                4'h3: seg = 8'hB0;
                4'h4: seg = 8'h99;
                4'h5: seg = 8'h92;
                4'h6: seg = 8'h82;
                4'h7: seg = 8'hF8;
                4'h8: seg = 8'h80;
                4'h9: seg = 8'h90;
                4'hA: seg = 8'h88;
                4'hB: seg = 8'h83;
                4'hC: seg = 8'hC6;
                4'hD: seg = 8'hA1;
                4'hE: seg = 8'h86;
                4'hF: seg = 8'h8E;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 key decoder: buffers receiver bytes in a small FIFO, strips
// E0/F0 prefixes, tracks the held key with its ASCII code and a press
// counter, and drives six 7-segment digits.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,   // power of two, at least 2
    parameter int CNT_W      = 8
)(
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             overflow,
    output logic             key_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic [7:0]       key_ascii,
    output logic [CNT_W-1:0] press_count,
    output logic [7:0]       hex0,
    output logic [7:0]       hex1,
    output logic [7:0]       hex2,
    output logic [7:0]       hex3,
    output logic [7:0]       hex4,
    output logic [7:0]       hex5
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Input FIFO: pointers carry one extra wrap bit to tell full from empty
    // ------------------------------------------------------------------
    logic [7:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr_reg;
    logic [PTR_W:0] rd_ptr_reg;
    logic           fifo_empty;
    logic           fifo_full;
    logic           push;
    logic           pop;
    logic [7:0]     pop_byte;
    logic           overflow_reg;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                        (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);

    // A push is judged on the fullness at the start of the cycle only, so a
    // same-cycle pop never frees room for a byte offered while full.
    assign in_ready = !fifo_full;
    assign push     = in_valid && !fifo_full;
    // The decoder never stalls: drain one byte every cycle there is one.
    assign pop      = !fifo_empty;
    // Read is asynchronous so the decoder sees the head byte in the pop cycle.
    assign pop_byte = fifo_mem[rd_ptr_reg[PTR_W-1:0]];

    // Storage write; contents need no reset since pointers gate every read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= in_data;
        end
    end

    // Pointer advance and sticky overflow flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (in_valid && fifo_full) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Prefix FSM and held-key state
    // ------------------------------------------------------------------
    ps2_state_t       state_reg,       state_next;
    logic             key_valid_reg,   key_valid_next;
    logic [7:0]       key_code_reg,    key_code_next;
    logic             key_ext_reg,     key_ext_next;
    logic [7:0]       key_ascii_reg,   key_ascii_next;
    logic [CNT_W-1:0] press_count_reg, press_count_next;
    // Count digits stay blank until the first press after reset
    logic             count_shown_reg, count_shown_next;

    logic is_make;
    logic is_break;
    logic byte_ext;
    logic same_key;

    // Register the decoder state; all of it updates only on popped bytes
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg       <= ST_IDLE;
            key_valid_reg   <= 1'b0;
            key_code_reg    <= 8'h00;
            key_ext_reg     <= 1'b0;
            key_ascii_reg   <= 8'h00;
            press_count_reg <= '0;
            count_shown_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            key_valid_reg   <= key_valid_next;
            key_code_reg    <= key_code_next;
            key_ext_reg     <= key_ext_next;
            key_ascii_reg   <= key_ascii_next;
            press_count_reg <= press_count_next;
            count_shown_reg <= count_shown_next;
        end
    end

    // Classify the popped byte as prefix, make or break, then apply it
    always_comb begin
        state_next       = state_reg;
        key_valid_next   = key_valid_reg;
        key_code_next    = key_code_reg;
        key_ext_next     = key_ext_reg;
        key_ascii_next   = key_ascii_reg;
        press_count_next = press_count_reg;
        count_shown_next = count_shown_reg;
        is_make          = 1'b0;
        is_break         = 1'b0;
        byte_ext         = 1'b0;

        if (pop) begin
            case (state_reg)
                ST_IDLE: begin
                    if (pop_byte == PS2_EXT) begin
                        state_next = ST_EXT;
                    end else if (pop_byte == PS2_BRK) begin
                        state_next = ST_BRK;
                    end else begin
                        is_make = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (pop_byte == PS2_BRK) begin
                        state_next = ST_EXT_BRK;
                    end else if (pop_byte == PS2_EXT) begin
                        // Repeated E0 keeps waiting for the real code
                        state_next = ST_EXT;
                    end else begin
                        is_make    = 1'b1;
                        byte_ext   = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    is_break   = 1'b1;
                    state_next = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    is_break   = 1'b1;
                    byte_ext   = 1'b1;
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end

        same_key = key_valid_reg && (key_ext_reg == byte_ext) &&
                   (key_code_reg == pop_byte);

        // A make of the already-held key is typematic repeat and is ignored
        if (is_make && !same_key) begin
            key_valid_next   = 1'b1;
            key_code_next    = pop_byte;
            key_ext_next     = byte_ext;
            key_ascii_next   = byte_ext ? 8'h00 : scan2ascii(pop_byte);
            press_count_next = press_count_reg + CNT_W'(1);
            count_shown_next = 1'b1;
        end

        // Only the release of the held key clears it; other breaks are noise
        if (is_break && same_key) begin
            key_valid_next = 1'b0;
        end
    end

    assign overflow    = overflow_reg;
    assign key_valid   = key_valid_reg;
    assign key_code    = key_code_reg;
    assign key_ext     = key_ext_reg;
    assign key_ascii   = key_ascii_reg;
    assign press_count = press_count_reg;

    // ------------------------------------------------------------------
    // Display: two digits each of code, ASCII and low count byte
    // ------------------------------------------------------------------
    logic [7:0] count_byte;

    generate
        if (CNT_W >= 8) begin : g_cnt_wide
            assign count_byte = press_count_reg[7:0];
        end else begin : g_cnt_narrow
            assign count_byte = {{(8 - CNT_W){1'b0}}, press_count_reg};
        end
    endgenerate

    logic [3:0] digit_nib   [6];
    logic       digit_blank [6];
    logic [7:0] digit_seg   [6];

    // Route registered values to digit positions with their blanking
    always_comb begin
        digit_nib[0]   = key_code_reg[3:0];
        digit_nib[1]   = key_code_reg[7:4];
        digit_nib[2]   = key_ascii_reg[3:0];
        digit_nib[3]   = key_ascii_reg[7:4];
        digit_nib[4]   = count_byte[3:0];
        digit_nib[5]   = count_byte[7:4];
        digit_blank[0] = !key_valid_reg;
        digit_blank[1] = !key_valid_reg;
        digit_blank[2] = !key_valid_reg;
        digit_blank[3] = !key_valid_reg;
        digit_blank[4] = !count_shown_reg;
        digit_blank[5] = !count_shown_reg;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_digit
            seg7_hex u_seg (
                .nibble (digit_nib[gi]),
                .blank  (digit_blank[gi]),
                .seg    (digit_seg[gi])
            );
        end
    endgenerate

    assign hex0 = digit_seg[0];
    assign hex1 = digit_seg[1];
    assign hex2 = digit_seg[2];
    assign hex3 = digit_seg[3];
    assign hex4 = digit_seg[4];
    assign hex5 = digit_seg[5];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: a reference model predicts the
// visible state after every accepted byte, the expectation is queued with
// its due cycle and compared when that cycle arrives.
module tb_ps2_key_decoder;

    localparam int CNT_W = 8;

    logic             clk;
    logic             resetn;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             overflow;
    logic             key_valid;
    logic [7:0]       key_code;
    logic             key_ext;
    logic [7:0]       key_ascii;
    logic [CNT_W-1:0] press_count;
    logic [7:0]       hex0, hex1, hex2, hex3, hex4, hex5;

    ps2_key_decoder #(.FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .overflow    (overflow),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .key_ascii   (key_ascii),
        .press_count (press_count),
        .hex0        (hex0),
        .hex1        (hex1),
        .hex2        (hex2),
        .hex3        (hex3),
        .hex4        (hex4),
        .hex5        (hex5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference tables
    localparam logic [7:0] SEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    localparam logic [7:0] LETTERS [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                            8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                            8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                            8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    localparam logic [7:0] DIGITS [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                           8'h3D, 8'h3E, 8'h46};
    localparam logic [73:0] RESET_VEC = {1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 48'hFFFF_FFFF_FFFF};

    // Reference model state
    int         m_state;   // 0 idle, 1 ext, 2 brk, 3 ext+brk
    logic       m_kv, m_ke, m_shown;
    logic [7:0] m_kc, m_ka, m_pc;

    typedef struct {
        int          due;
        logic [7:0]  b;
        logic [73:0] v;
    } exp_t;

    exp_t sb[$];

    function automatic logic [7:0] ascii_of(input logic [7:0] c);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 26; i++) if (LETTERS[i] == c) r = 8'(8'h61 + i);
        for (int i = 0; i < 10; i++) if (DIGITS[i] == c)  r = 8'(8'h30 + i);
        if (c == 8'h29) r = 8'h20;
        if (c == 8'h5A) r = 8'h0D;
        return r;
    endfunction

    function automatic logic [73:0] model_vec();
        logic [7:0] h0, h1, h2, h3, h4, h5;
        h0 = m_kv ? SEG[m_kc[3:0]] : 8'hFF;
        h1 = m_kv ? SEG[m_kc[7:4]] : 8'hFF;
        h2 = m_kv ? SEG[m_ka[3:0]] : 8'hFF;
        h3 = m_kv ? SEG[m_ka[7:4]] : 8'hFF;
        h4 = m_shown ? SEG[m_pc[3:0]] : 8'hFF;
        h5 = m_shown ? SEG[m_pc[7:4]] : 8'hFF;
        return {m_kv, m_kc, m_ke, m_ka, m_pc, h5, h4, h3, h2, h1, h0};
    endfunction

    function automatic logic [73:0] dut_vec();
        return {key_valid, key_code, key_ext, key_ascii, press_count,
                hex5, hex4, hex3, hex2, hex1, hex0};
    endfunction

    task automatic model_reset();
        m_state = 0; m_kv = 0; m_ke = 0; m_shown = 0;
        m_kc = 0; m_ka = 0; m_pc = 0;
    endtask

    task automatic model_step(input logic [7:0] b);
        logic mk, bk, e;
        mk = 0; bk = 0; e = 0;
        case (m_state)
            0: if (b == 8'hE0) m_state = 1; else if (b == 8'hF0) m_state = 2; else mk = 1;
            1: if (b == 8'hF0) m_state = 3; else if (b == 8'hE0) m_state = 1;
               else begin mk = 1; e = 1; m_state = 0; end
            2: begin bk = 1; m_state = 0; end
            default: begin bk = 1; e = 1; m_state = 0; end
        endcase
        if (mk && !(m_kv && m_ke == e && m_kc == b)) begin
            m_kv = 1; m_kc = b; m_ke = e; m_ka = e ? 8'h00 : ascii_of(b);
            m_pc = m_pc + 8'd1; m_shown = 1;
        end
        if (bk && m_kv && m_ke == e && m_kc == b) m_kv = 0;
    endtask

    // Advance to the next falling edge and compare every expectation now due
    task automatic tick();
        exp_t e;
        @(negedge clk);
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            n_cmp++;
            if (e.due != cyc || dut_vec() !== e.v) begin
                n_bad++;
                $display("FAIL sb byte=%02h cyc=%0d due=%0d got=%h want=%h",
                         e.b, cyc, e.due, dut_vec(), e.v);
            end else begin
                $display("txn byte=%02h kv=%0b code=%02h ext=%0b ascii=%02h cnt=%02h",
                         e.b, key_valid, key_code, key_ext, key_ascii, press_count);
            end
        end
    endtask

    // Offer one byte for one cycle; predicted outcome is queued if accepted
    task automatic send(input logic [7:0] b, output logic acc);
        exp_t e;
        tick();
        in_data  = b;
        in_valid = 1'b1;
        acc      = in_ready;
        if (in_ready) begin
            model_step(b);
            e.due = cyc + 2;
            e.b   = b;
            e.v   = model_vec();
            sb.push_back(e);
        end
    endtask

    // Stop offering and wait, bounded, for every expectation to be compared
    task automatic settle();
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            n_cmp++; n_bad++;
            $display("FAIL settle_timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        tick();
        in_valid = 1'b0;
        resetn   = 1'b0;
        tick();
        resetn = 1'b1;
        model_reset();
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (dut_vec() !== RESET_VEC) begin
            n_bad++; $display("FAIL reset_state got=%h want=%h", dut_vec(), RESET_VEC);
        end
        n_cmp++;
        if ({in_ready, overflow} !== 2'b10) begin
            n_bad++; $display("FAIL reset_flags got=%b want=10", {in_ready, overflow});
        end
    endtask

    task automatic test_make_break();
        logic acc;
        do_reset();
        send(8'h1C, acc);
        settle();
        n_cmp++;
        if ({key_valid, key_code, key_ascii, press_count, hex1, hex0} !==
            {1'b1, 8'h1C, 8'h61, 8'h01, 8'hF9, 8'hC6}) begin
            n_bad++;
            $display("FAIL make_a got=%b/%02h/%02h/%02h/%02h/%02h want=1/1c/61/01/f9/c6",
                     key_valid, key_code, key_ascii, press_count, hex1, hex0);
        end
        send(8'hF0, acc);
        send(8'h1C, acc);
        settle();
        n_cmp++;
        if ({key_valid, hex3, hex2, hex1, hex0, hex4} !== {1'b0, 32'hFFFF_FFFF, 8'hF9}) begin
            n_bad++;
            $display("FAIL break_a got=%b/%02h%02h%02h%02h/%02h want=0/ffffffff/f9",
                     key_valid, hex3, hex2, hex1, hex0, hex4);
        end
    endtask

    task automatic test_typematic();
        logic acc;
        do_reset();
        for (int i = 0; i < 3; i++) send(8'h1C, acc);
        send(8'hF0, acc);
        send(8'h1C, acc);
        settle();
        n_cmp++;
        if ({key_valid, press_count} !== {1'b0, 8'h01}) begin
            n_bad++;
            $display("FAIL typematic got=%b/%02h want=0/01", key_valid, press_count);
        end
    endtask

    task automatic test_extended();
        logic acc;
        do_reset();
        send(8'hE0, acc);
        send(8'h75, acc);
        settle();
        n_cmp++;
        if ({key_valid, key_ext, key_code, key_ascii, press_count} !==
            {1'b1, 1'b1, 8'h75, 8'h00, 8'h01}) begin
            n_bad++;
            $display("FAIL ext_make got=%b/%b/%02h/%02h/%02h want=1/1/75/00/01",
                     key_valid, key_ext, key_code, key_ascii, press_count);
        end
        send(8'hF0, acc);
        send(8'h75, acc);
        settle();
        n_cmp++;
        if (key_valid !== 1'b1) begin
            n_bad++; $display("FAIL ext_plain_break got=%b want=1", key_valid);
        end
        send(8'hE0, acc);
        send(8'hF0, acc);
        send(8'h75, acc);
        settle();
        n_cmp++;
        if (key_valid !== 1'b0) begin
            n_bad++; $display("FAIL ext_break got=%b want=0", key_valid);
        end
    endtask

    task automatic test_rollover();
        logic acc;
        do_reset();
        send(8'h16, acc);
        send(8'h32, acc);
        send(8'hF0, acc);
        send(8'h16, acc);
        settle();
        n_cmp++;
        if ({key_valid, key_code, key_ascii, press_count} !== {1'b1, 8'h32, 8'h62, 8'h02}) begin
            n_bad++;
            $display("FAIL rollover got=%b/%02h/%02h/%02h want=1/32/62/02",
                     key_valid, key_code, key_ascii, press_count);
        end
    endtask

    task automatic test_back_to_back();
        logic acc;
        logic [7:0] seq [6];
        seq = '{8'h1C, 8'hF0, 8'h1C, 8'h5A, 8'h29, 8'h45};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send(seq[i], acc);
            n_cmp++;
            if (acc !== 1'b1) begin
                n_bad++; $display("FAIL b2b_ready idx=%0d got=%b want=1", i, acc);
            end
        end
        settle();
        n_cmp++;
        if ({overflow, press_count, key_ascii} !== {1'b0, 8'h04, 8'h30}) begin
            n_bad++;
            $display("FAIL b2b_end got=%b/%02h/%02h want=0/04/30", overflow, press_count, key_ascii);
        end
    endtask

    task automatic test_overflow();
        logic rdy;
        do_reset();
        tick();
        force dut.pop = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            in_data  = 8'hF0;
            in_valid = 1'b1;
            rdy      = in_ready;
            n_cmp++;
            if (rdy !== (i < 4)) begin
                n_bad++; $display("FAIL ovf_ready idx=%0d got=%b want=%b", i, rdy, (i < 4));
            end
        end
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if ({in_ready, overflow} !== 2'b01) begin
            n_bad++; $display("FAIL ovf_set got=%b want=01", {in_ready, overflow});
        end
        release dut.pop;
        for (int i = 0; i < 8; i++) tick();
        n_cmp++;
        if ({in_ready, overflow} !== 2'b11) begin
            n_bad++; $display("FAIL ovf_sticky got=%b want=11", {in_ready, overflow});
        end
        do_reset();
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++; $display("FAIL ovf_clear got=%b want=0", overflow);
        end
    endtask

    task automatic test_wrap();
        logic acc;
        do_reset();
        for (int i = 0; i < 255; i++) send((i % 2 == 0) ? 8'h1C : 8'h32, acc);
        settle();
        n_cmp++;
        if (press_count !== 8'hFF) begin
            n_bad++; $display("FAIL wrap_pre got=%02h want=ff", press_count);
        end
        send(8'h29, acc);
        settle();
        n_cmp++;
        if ({press_count, hex5, hex4, key_ascii} !== {8'h00, 8'hC0, 8'hC0, 8'h20}) begin
            n_bad++;
            $display("FAIL wrap got=%02h/%02h/%02h/%02h want=00/c0/c0/20",
                     press_count, hex5, hex4, key_ascii);
        end
    endtask

    task automatic test_reset_midstream();
        logic acc;
        do_reset();
        send(8'h1C, acc);
        send(8'hF0, acc);
        settle();
        #2 resetn = 1'b0;
        #1;
        n_cmp++;
        if ({dut_vec(), in_ready, overflow} !== {RESET_VEC, 2'b10}) begin
            n_bad++;
            $display("FAIL async_reset got=%h/%b want=%h/10", dut_vec(), {in_ready, overflow}, RESET_VEC);
        end
        tick();
        resetn = 1'b1;
        model_reset();
        sb.delete();
        send(8'h1C, acc);
        settle();
        n_cmp++;
        if ({key_valid, press_count} !== {1'b1, 8'h01}) begin
            n_bad++;
            $display("FAIL post_reset_make got=%b/%02h want=1/01", key_valid, press_count);
        end
    endtask

    initial begin
        resetn   = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        model_reset();
        test_reset();
        test_make_break();
        test_typematic();
        test_extended();
        test_rollover();
        test_back_to_back();
        test_overflow();
        test_wrap();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout cyc=%0d limit=20000", cyc);
        $fatal(1, "watchdog");
    end

endmodule
